// File: rtl/pe_mac_pipe.sv
// rtl/pe_mac_pipe.sv - pipelined signed LANES-wide dot-product MAC with valid/ready on both sides
// Optional saturation of the partial-sum add is enabled by defining PE_SAT_EN.
module pe_mac_pipe #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*DW-1:0]   neuron,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [1:0]            ctl,
  input  logic                  vld_i,
  output logic                  rdy_o,
  output logic [ACC_W-1:0]      result,
  output logic                  vld_o,
  input  logic                  rdy_i,
  output logic                  ovf_o
);

  localparam int PW = 2 * DW;

  if (ACC_W < 2 * DW + $clog2(LANES)) begin : g_bad_acc_w
    $error("pe_mac_pipe: ACC_W must be at least 2*DW+clog2(LANES)");
  end
  if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("pe_mac_pipe: LANES must be a power of two and at least 2");
  end

  // One global advance: the whole pipe freezes while a result waits on downstream.
  logic adv;
  assign adv   = ~(vld_o & ~rdy_i);
  assign rdy_o = adv;

  // S1: per-lane signed products, computed on sign-extended operands.
  logic [LANES-1:0][PW-1:0] prod;
  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = {{DW{neuron[i*DW+DW-1]}}, neuron[i*DW +: DW]}
              * {{DW{weight[i*DW+DW-1]}}, weight[i*DW +: DW]};
    end
  end

  logic                     s1_vld;
  logic [1:0]               s1_ctl;
  logic [LANES-1:0][PW-1:0] s1_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_ctl <= 2'b00;
      s1_p   <= '0;
    end else if (adv) begin
      s1_vld <= vld_i;
      s1_ctl <= ctl;
      if (vld_i) s1_p <= prod;
    end
  end

  // S2: reduction; the width rule guarantees the sum cannot overflow ACC_W.
  logic [ACC_W-1:0] tree_sum;
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + {{(ACC_W-PW){s1_p[i][PW-1]}}, s1_p[i]};
    end
  end

  logic             s2_vld;
  logic [1:0]       s2_ctl;
  logic [ACC_W-1:0] s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_ctl <= 2'b00;
      s2_sum <= '0;
    end else if (adv) begin
      s2_vld <= s1_vld;
      s2_ctl <= s1_ctl;
      if (s1_vld) s2_sum <= tree_sum;
    end
  end

  // S3: partial-sum accumulate and result emission.
  logic [ACC_W-1:0] psum;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] psum_d;
  assign base = s2_ctl[0] ? '0 : psum;

`ifdef PE_SAT_EN
  logic [ACC_W:0] wide_sum;
  logic           ovf_now;
  logic           psum_ovf;
  logic           ovf_d;

  always_comb begin
    wide_sum = {base[ACC_W-1], base} + {s2_sum[ACC_W-1], s2_sum};
    ovf_now  = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    psum_d   = wide_sum[ACC_W-1:0];
    if (ovf_now) begin
      psum_d = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    ovf_d = (s2_ctl[0] ? 1'b0 : psum_ovf) | ovf_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_ovf <= 1'b0;
      ovf_o    <= 1'b0;
    end else if (adv && s2_vld) begin
      psum_ovf <= ovf_d;
      if (s2_ctl[1]) ovf_o <= ovf_d;
    end
  end
`else
  assign psum_d = base + s2_sum;
  assign ovf_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum   <= '0;
      result <= '0;
      vld_o  <= 1'b0;
    end else if (adv) begin
      if (s2_vld) psum <= psum_d;
      // adv implies any pending result is being consumed on this edge.
      if (s2_vld && s2_ctl[1]) begin
        result <= psum_d;
        vld_o  <= 1'b1;
      end else begin
        vld_o  <= 1'b0;
      end
    end
  end

endmodule
